// File: rtl/spinner_pkg.sv
// spinner_quad_gen shared types and helpers.
// Gray phase stepping and saturating accumulator add.
package spinner_pkg;

  localparam int SAT_W = 32;

  function automatic logic [1:0] gray_next(
    input logic [1:0] ph,
    input logic       dir
  );
    logic [1:0] n;
    n = 2'b00;
    if (dir) begin
      unique case (ph)
        2'b00:   n = 2'b10;
        2'b10:   n = 2'b11;
        2'b11:   n = 2'b01;
        default: n = 2'b00;
      endcase
    end else begin
      unique case (ph)
        2'b00:   n = 2'b01;
        2'b01:   n = 2'b11;
        2'b11:   n = 2'b10;
        default: n = 2'b00;
      endcase
    end
    return n;
  endfunction

  // Result is clamped to the signed range of a w-bit register.
  function automatic logic signed [SAT_W-1:0] sat_add(
    input logic signed [SAT_W-1:0] a,
    input logic signed [SAT_W-1:0] b,
    input int                      w
  );
    logic signed [SAT_W:0] s;
    logic signed [SAT_W:0] hi;
    logic signed [SAT_W:0] lo;
    s  = {a[SAT_W-1], a} + {b[SAT_W-1], b};
    hi = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo = -(33'sd1 <<< (w - 1));
    if (s > hi)
      return SAT_W'(hi);
    else if (s < lo)
      return SAT_W'(lo);
    else
      return SAT_W'(s);
  endfunction

endpackage

// File: rtl/spinner_chan.sv
// One spinner channel: owed-step accumulator,
// digital repeat counter and Gray phase register.
module spinner_chan
  import spinner_pkg::*;
#(
  parameter int POS_W     = 12,
  parameter int DELTA_W   = 9,
  parameter int REPEAT    = 48000,
  parameter int SLOW_STEP = 4,
  parameter int FAST_STEP = 9
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               ce,
  input  logic               step_tick,
  input  logic               delta_strobe,
  input  logic [DELTA_W-1:0] delta,
  input  logic               dig_left,
  input  logic               dig_right,
  input  logic               dig_fast,
  input  logic               invert,
  output logic [1:0]         quad,
  output logic [POS_W-1:0]   pending,
  output logic               busy
);

  localparam int REP_W = $clog2(REPEAT + 1);
  localparam logic [REP_W-1:0] REP_LAST =
    REP_W'(REPEAT - 1);
  localparam logic signed [POS_W-1:0] SLOW =
    POS_W'(SLOW_STEP);
  localparam logic signed [POS_W-1:0] FAST =
    POS_W'(FAST_STEP);
  localparam logic signed [POS_W-1:0] ONE =
    POS_W'(1);

  logic signed [POS_W-1:0] pos;
  logic signed [POS_W-1:0] base;
  logic signed [POS_W-1:0] nxt;
  logic [REP_W-1:0]        rep;
  logic [1:0]              phase;
  logic                    held;
  logic                    reload;
  logic                    step;
  logic                    dir;

  assign held   = dig_left | dig_right;
  assign reload = ce & held & (rep == REP_LAST);
  assign step   = step_tick & (pos != '0);
  assign dir    = ~pos[POS_W-1] ^ invert;

  // Overwrite from digital controls wins over a step,
  // then any delta is merged on top with saturation.
  always_comb begin
    base = pos;
    if (reload) begin
      if (dig_right)
        base = dig_fast ? FAST : SLOW;
      else
        base = dig_fast ? -FAST : -SLOW;
    end else if (step) begin
      base = pos[POS_W-1] ? pos + ONE : pos - ONE;
    end
    nxt = base;
    if (delta_strobe)
      nxt = POS_W'(sat_add(
        {{(SAT_W-POS_W){base[POS_W-1]}}, base},
        {{(SAT_W-DELTA_W){delta[DELTA_W-1]}}, delta},
        POS_W));
  end

  // Accumulator state.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)
      pos <= '0;
    else
      pos <= nxt;
  end

  // Repeat counter runs only while a direction is held.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)
      rep <= '0;
    else if (!held)
      rep <= '0;
    else if (ce)
      rep <= (rep == REP_LAST) ? '0 : rep + 1'b1;
  end

  // Phase advances one Gray step per owed step.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)
      phase <= 2'b00;
    else if (step)
      phase <= gray_next(phase, dir);
  end

  assign quad    = phase;
  assign pending = pos;
  assign busy    = (pos != '0);

endmodule

// File: rtl/spinner_quad_gen.sv
// Multi-channel quadrature spinner emulator.
// Shared step divider plus N independent channels.
module spinner_quad_gen
  import spinner_pkg::*;
#(
  parameter int CHANNELS  = 2,
  parameter int POS_W     = 12,
  parameter int DELTA_W   = 9,
  parameter int DIV       = 1500,
  parameter int REPEAT    = 48000,
  parameter int SLOW_STEP = 4,
  parameter int FAST_STEP = 9
) (
  input  logic                        clk_sys,
  input  logic                        reset,
  input  logic                        ce,
  input  logic [CHANNELS-1:0]         delta_strobe,
  input  logic [CHANNELS*DELTA_W-1:0] delta,
  input  logic [CHANNELS-1:0]         dig_left,
  input  logic [CHANNELS-1:0]         dig_right,
  input  logic [CHANNELS-1:0]         dig_fast,
  input  logic [CHANNELS-1:0]         invert,
  output logic [2*CHANNELS-1:0]       quad,
  output logic [CHANNELS*POS_W-1:0]   pending,
  output logic [CHANNELS-1:0]         busy
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST =
    DIV_W'(DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             step_tick;

  assign step_tick = ce & (div_cnt == '0);

  // Shared divider counting ce pulses modulo DIV.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)
      div_cnt <= '0;
    else if (ce)
      div_cnt <= (div_cnt == DIV_LAST) ? '0
                                       : div_cnt + 1'b1;
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    spinner_chan #(
      .POS_W    (POS_W),
      .DELTA_W  (DELTA_W),
      .REPEAT   (REPEAT),
      .SLOW_STEP(SLOW_STEP),
      .FAST_STEP(FAST_STEP)
    ) u_chan (
      .clk_sys     (clk_sys),
      .reset       (reset),
      .ce          (ce),
      .step_tick   (step_tick),
      .delta_strobe(delta_strobe[i]),
      .delta       (delta[i*DELTA_W +: DELTA_W]),
      .dig_left    (dig_left[i]),
      .dig_right   (dig_right[i]),
      .dig_fast    (dig_fast[i]),
      .invert      (invert[i]),
      .quad        (quad[2*i +: 2]),
      .pending     (pending[i*POS_W +: POS_W]),
      .busy        (busy[i])
    );
  end

endmodule

// File: tb/tb_spinner_quad_gen.sv
// Self-checking bench for spinner_quad_gen.
// Two channels, DIV=4, REPEAT=10.
module tb_spinner_quad_gen;

  localparam int CH = 2;
  localparam int PW = 12;
  localparam int DW = 9;

  logic            clk_sys = 1'b0;
  logic            reset;
  logic            ce;
  logic [CH-1:0]   delta_strobe;
  logic [CH*DW-1:0] delta;
  logic [CH-1:0]   dig_left;
  logic [CH-1:0]   dig_right;
  logic [CH-1:0]   dig_fast;
  logic [CH-1:0]   invert;
  logic [2*CH-1:0] quad;
  logic [CH*PW-1:0] pending;
  logic [CH-1:0]   busy;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    int d0;
    int d1;
    int e0;
    int e1;
  } vec_t;

  typedef struct {
    int e0;
    int e1;
  } sb_t;

  typedef struct {
    logic [1:0] q;
    int         p;
  } step_t;

  vec_t  tbl[12];
  sb_t   sb_q[$];
  step_t exp_q0[$];
  step_t exp_q1[$];
  int    cyc0[$];
  int    cyc1[$];

  spinner_quad_gen #(
    .CHANNELS (CH),
    .POS_W    (PW),
    .DELTA_W  (DW),
    .DIV      (4),
    .REPEAT   (10),
    .SLOW_STEP(4),
    .FAST_STEP(9)
  ) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .ce          (ce),
    .delta_strobe(delta_strobe),
    .delta       (delta),
    .dig_left    (dig_left),
    .dig_right   (dig_right),
    .dig_fast    (dig_fast),
    .invert      (invert),
    .quad        (quad),
    .pending     (pending),
    .busy        (busy)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic int pend(input int c);
    logic signed [PW-1:0] v;
    v = pending[c*PW +: PW];
    return int'(v);
  endfunction

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    ce           = 1'b0;
    delta_strobe = '0;
    delta        = '0;
    dig_left     = '0;
    dig_right    = '0;
    dig_fast     = '0;
    invert       = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    exp_q0.delete();
    exp_q1.delete();
    cyc0.delete();
    cyc1.delete();
  endtask

  task automatic load(input int d0, input int d1);
    delta        = {DW'(d1), DW'(d0)};
    delta_strobe = 2'b11;
    tick();
    delta_strobe = '0;
  endtask

  // Run with ce high; every observed quad edge is
  // matched against the next expected step.
  task automatic watch(input int n);
    logic [1:0] p0;
    logic [1:0] p1;
    step_t e;
    p0 = quad[1:0];
    p1 = quad[3:2];
    ce = 1'b1;
    for (int t = 0; t < n; t++) begin
      tick();
      if (quad[1:0] != p0) begin
        cyc0.push_back(t);
        if (exp_q0.size() == 0) begin
          chk("ch0_extra_step", int'(quad[1:0]), int'(p0));
        end else begin
          e = exp_q0.pop_front();
          chk("ch0_quad", int'(quad[1:0]), int'(e.q));
          chk("ch0_pend", pend(0), e.p);
        end
        p0 = quad[1:0];
      end
      if (quad[3:2] != p1) begin
        cyc1.push_back(t);
        if (exp_q1.size() == 0) begin
          chk("ch1_extra_step", int'(quad[3:2]), int'(p1));
        end else begin
          e = exp_q1.pop_front();
          chk("ch1_quad", int'(quad[3:2]), int'(e.q));
          chk("ch1_pend", pend(1), e.p);
        end
        p1 = quad[3:2];
      end
    end
    ce = 1'b0;
    chk("ch0_missing_steps", exp_q0.size(), 0);
    chk("ch1_missing_steps", exp_q1.size(), 0);
  endtask

  initial begin
    sb_t s;

    for (int k = 0; k < 8; k++)
      tbl[k] = '{255, -255, 255*(k+1), -255*(k+1)};
    tbl[8]  = '{255, -256, 2047, -2048};
    tbl[9]  = '{1, -1, 2047, -2048};
    tbl[10] = '{-256, 255, 1791, -1793};
    tbl[11] = '{-255, 0, 1536, -1793};

    do_reset();
    chk("rst_quad", int'(quad), 0);
    chk("rst_pend0", pend(0), 0);
    chk("rst_pend1", pend(1), 0);
    chk("rst_busy", int'(busy), 0);

    // Saturating accumulation, ce held low.
    for (int i = 0; i < 12; i++) begin
      sb_q.push_back('{tbl[i].e0, tbl[i].e1});
      load(tbl[i].d0, tbl[i].d1);
      s = sb_q.pop_front();
      chk($sformatf("vec%0d_p0", i), pend(0), s.e0);
      chk($sformatf("vec%0d_p1", i), pend(1), s.e1);
      chk($sformatf("vec%0d_busy", i), int'(busy),
          ((s.e1 != 0) ? 2 : 0) | ((s.e0 != 0) ? 1 : 0));
    end
    chk("sat_quad_idle", int'(quad), 0);

    // +3 on channel 0, positive Gray order.
    do_reset();
    load(3, 0);
    chk("a_pend_load", pend(0), 3);
    exp_q0.push_back('{2'b10, 2});
    exp_q0.push_back('{2'b11, 1});
    exp_q0.push_back('{2'b01, 0});
    watch(20);
    chk("a_busy_low", int'(busy[0]), 0);
    chk("a_quad_hold", int'(quad[1:0]), 1);
    if (cyc0.size() == 3) begin
      chk("a_gap1", cyc0[1] - cyc0[0], 4);
      chk("a_gap2", cyc0[2] - cyc0[1], 4);
    end

    // -2 with invert: positive order, count to zero.
    do_reset();
    invert = 2'b01;
    load(-2, 0);
    chk("b_pend_load", pend(0), -2);
    exp_q0.push_back('{2'b10, -1});
    exp_q0.push_back('{2'b11, 0});
    watch(16);
    chk("b_busy_low", int'(busy[0]), 0);

    // Strobe coincident with step_tick.
    do_reset();
    load(5, 0);
    chk("c_pend_load", pend(0), 5);
    ce           = 1'b1;
    delta        = {DW'(0), DW'(1)};
    delta_strobe = 2'b01;
    tick();
    ce           = 1'b0;
    delta_strobe = '0;
    chk("c_pend_merge", pend(0), 5);
    chk("c_quad_once", int'(quad[1:0]), 2);
    tick();
    chk("c_pend_hold", pend(0), 5);

    // Digital reload: ch0 right+fast, ch1 left slow.
    do_reset();
    dig_right = 2'b01;
    dig_fast  = 2'b01;
    dig_left  = 2'b10;
    ce        = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    chk("d_pre_p0", pend(0), 0);
    chk("d_pre_p1", pend(1), 0);
    tick();
    ce = 1'b0;
    chk("d_fast_right", pend(0), 9);
    chk("d_slow_left", pend(1), -4);
    chk("d_busy", int'(busy), 3);

    // Release clears rep; both held favours right.
    do_reset();
    dig_right = 2'b11;
    dig_left  = 2'b10;
    ce        = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    dig_right = 2'b00;
    dig_left  = 2'b00;
    tick();
    dig_right = 2'b11;
    dig_left  = 2'b10;
    for (int i = 0; i < 9; i++) tick();
    chk("e_no_reload_p0", pend(0), 0);
    chk("e_no_reload_p1", pend(1), 0);
    tick();
    ce = 1'b0;
    chk("e_reload_p0", pend(0), 4);
    chk("e_right_wins", pend(1), 4);
    dig_right = '0;
    dig_left  = '0;

    // Independent channels on a shared step_tick.
    do_reset();
    load(2, -3);
    exp_q0.push_back('{2'b10, 1});
    exp_q0.push_back('{2'b11, 0});
    exp_q1.push_back('{2'b01, -2});
    exp_q1.push_back('{2'b11, -1});
    exp_q1.push_back('{2'b10, 0});
    watch(20);
    chk("f_n0", cyc0.size(), 2);
    chk("f_n1", cyc1.size(), 3);
    if (cyc0.size() == 2 && cyc1.size() == 3) begin
      chk("f_align0", cyc0[0], cyc1[0]);
      chk("f_align1", cyc0[1], cyc1[1]);
      chk("f_gap", cyc1[2] - cyc1[1], 4);
    end
    chk("f_busy", int'(busy), 0);

    // Reset mid-run drops owed steps.
    do_reset();
    load(7, -7);
    ce = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("g_async_quad", int'(quad), 0);
    chk("g_async_pend", pend(0), 0);
    tick();
    reset = 1'b0;
    ce    = 1'b0;
    tick();
    chk("g_busy", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
